// File: rtl/instr_register_alu_seq_if.sv
// Bundle of write-handshake, commit-notify and read-port signals of the instruction register.
// master: stimulus/driver side (offers instructions, issues reads).
// slave : instruction register (accepts instructions, returns stored entries).
interface instr_register_alu_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int RES_W = 2 * DATA_W;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] write_pointer;
    logic [2:0]        opcode;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              wr_done;
    logic              rd_req;
    logic [ADDR_W-1:0] read_pointer;
    logic              rd_valid;
    logic [2:0]        rd_opcode;
    logic [DATA_W-1:0] rd_op_a;
    logic [DATA_W-1:0] rd_op_b;
    logic [RES_W-1:0]  rd_result;
    logic              rd_err;
    logic              rd_written;

    modport master (
        output wr_valid, write_pointer, opcode, operand_a, operand_b, rd_req, read_pointer,
        input  wr_ready, wr_done, rd_valid, rd_opcode, rd_op_a, rd_op_b, rd_result, rd_err, rd_written
    );

    modport slave (
        input  wr_valid, write_pointer, opcode, operand_a, operand_b, rd_req, read_pointer,
        output wr_ready, wr_done, rd_valid, rd_opcode, rd_op_a, rd_op_b, rd_result, rd_err, rd_written
    );
endinterface

// File: rtl/instr_register_alu_seq.sv
// Instruction store with integrated sequential ALU: DEPTH entries of {opcode, operands, result, err, written}.
// Latency: commit one edge after accept, DATA_W+2 edges for DIV/MOD with nonzero divisor; reads return next cycle.
// Backpressure: wr_ready high only in IDLE (source holds its offer); reads never stall.
// Ports: clk, reset_n (synchronous, active-low), bus (slave modport: write handshake, wr_done, read port).
module instr_register_alu_seq #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int RES_W  = 2 * DATA_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    instr_register_alu_seq_if.slave  bus
);
    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_DIVIDE = 2'd2;
    localparam logic [1:0] S_WRITE  = 2'd3;

    localparam int CNT_W = $clog2(DATA_W);

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_done_q;

    logic              rd_valid_q, rd_err_q, rd_written_q;
    logic [2:0]        rd_opcode_q;
    logic [DATA_W-1:0] rd_op_a_q, rd_op_b_q;
    logic [RES_W-1:0]  rd_result_q;

    logic [2:0]        mem_op      [DEPTH];
    logic [DATA_W-1:0] mem_a       [DEPTH];
    logic [DATA_W-1:0] mem_b       [DEPTH];
    logic [RES_W-1:0]  mem_res     [DEPTH];
    logic              mem_err     [DEPTH];
    logic              mem_written [DEPTH];

    logic accept, is_divmod, div_by_zero;
    assign bus.wr_ready = (state_q == S_IDLE);
    assign accept       = bus.wr_valid && (state_q == S_IDLE);
    assign is_divmod    = (op_q == OP_DIV) || (op_q == OP_MOD);
    assign div_by_zero  = is_divmod && (b_q == '0);

    // Single-cycle ops work on sign-extended operands so ADD/SUB never wrap and
    // the low RES_W bits of the product equal the full signed product.
    logic [RES_W-1:0] a_ext, b_ext, alu_res;
    assign a_ext = {{DATA_W{a_q[DATA_W-1]}}, a_q};
    assign b_ext = {{DATA_W{b_q[DATA_W-1]}}, b_q};

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_PASSA: alu_res = a_ext;
            OP_PASSB: alu_res = b_ext;
            OP_ADD:   alu_res = a_ext + b_ext;
            OP_SUB:   alu_res = a_ext - b_ext;
            OP_MULT:  alu_res = a_ext * b_ext;
            default:  alu_res = '0;   // ZERO, and DIV/MOD by zero
        endcase
    end

    // Restoring divider on magnitudes; quo_q starts as |a| and is shifted out
    // MSB-first while quotient bits shift in at the bottom.
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   rem_shift, trial;
    logic [RES_W-1:0]  quo_ext, rem_ext, div_res;

    assign a_neg     = a_q[DATA_W-1];
    assign b_neg     = b_q[DATA_W-1];
    assign a_mag     = a_neg ? (-a_q) : a_q;
    assign b_mag     = b_neg ? (-b_q) : b_q;
    assign rem_shift = {rem_q, quo_q[DATA_W-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};   // trial[DATA_W]=1 means borrow
    assign quo_ext   = {{DATA_W{1'b0}}, quo_q};
    assign rem_ext   = {{DATA_W{1'b0}}, rem_q};

    // Quotient negative when signs differ; remainder follows the dividend.
    always_comb begin
        if (op_q == OP_DIV) begin
            div_res = (a_neg ^ b_neg) ? (-quo_ext) : quo_ext;
        end else begin
            div_res = a_neg ? (-rem_ext) : rem_ext;
        end
    end

    logic             commit, commit_err;
    logic [RES_W-1:0] commit_res;

    always_comb begin
        state_d    = state_q;
        commit     = 1'b0;
        commit_err = 1'b0;
        commit_res = alu_res;
        case (state_q)
            S_IDLE: begin
                if (bus.wr_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_divmod && !div_by_zero) begin
                    state_d = S_DIVIDE;
                end else begin
                    commit     = 1'b1;
                    commit_err = div_by_zero;
                    state_d    = S_IDLE;
                end
            end
            S_DIVIDE: begin
                if (cnt_q == '0) state_d = S_WRITE;
            end
            S_WRITE: begin
                commit     = 1'b1;
                commit_res = div_res;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            ptr_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            cnt_q        <= '0;
            wr_done_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_opcode_q  <= '0;
            rd_op_a_q    <= '0;
            rd_op_b_q    <= '0;
            rd_result_q  <= '0;
            rd_err_q     <= 1'b0;
            rd_written_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_op[i]      <= '0;
                mem_a[i]       <= '0;
                mem_b[i]       <= '0;
                mem_res[i]     <= '0;
                mem_err[i]     <= 1'b0;
                mem_written[i] <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            wr_done_q <= commit;

            if (accept) begin
                op_q  <= bus.opcode;
                a_q   <= bus.operand_a;
                b_q   <= bus.operand_b;
                ptr_q <= bus.write_pointer;
            end

            if (state_q == S_EXEC) begin
                rem_q <= '0;
                quo_q <= a_mag;
                dvs_q <= b_mag;
                cnt_q <= CNT_W'(DATA_W - 1);
            end else if (state_q == S_DIVIDE) begin
                rem_q <= trial[DATA_W] ? rem_shift[DATA_W-1:0] : trial[DATA_W-1:0];
                quo_q <= {quo_q[DATA_W-2:0], ~trial[DATA_W]};
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (commit) begin
                mem_op[ptr_q]      <= op_q;
                mem_a[ptr_q]       <= a_q;
                mem_b[ptr_q]       <= b_q;
                mem_res[ptr_q]     <= commit_res;
                mem_err[ptr_q]     <= commit_err;
                mem_written[ptr_q] <= 1'b1;
            end

            // Memory writes are non-blocking, so a read landing on the commit
            // edge of the same entry returns the previous contents.
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) begin
                rd_opcode_q  <= mem_op[bus.read_pointer];
                rd_op_a_q    <= mem_a[bus.read_pointer];
                rd_op_b_q    <= mem_b[bus.read_pointer];
                rd_result_q  <= mem_res[bus.read_pointer];
                rd_err_q     <= mem_err[bus.read_pointer];
                rd_written_q <= mem_written[bus.read_pointer];
            end
        end
    end

    assign bus.wr_done    = wr_done_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_opcode  = rd_opcode_q;
    assign bus.rd_op_a    = rd_op_a_q;
    assign bus.rd_op_b    = rd_op_b_q;
    assign bus.rd_result  = rd_result_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.rd_written = rd_written_q;
endmodule

// File: tb/tb_instr_register_alu_seq.sv
module tb_instr_register_alu_seq;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int RES_W  = 2 * DATA_W;

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_register_alu_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_register_alu_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic              written;
        logic              err;
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [RES_W-1:0]  res;
    } entry_t;

    typedef struct {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ADDR_W-1:0] ptr;
        logic [RES_W-1:0]  res;
        logic              err;
    } vec_t;

    entry_t shadow [DEPTH];
    entry_t exp_q  [$];
    vec_t   tbl    [$];
    int     n_vec = 0;
    int     n_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic entry_t rd_entry();
        return {bus.rd_written, bus.rd_err, bus.rd_opcode, bus.rd_op_a, bus.rd_op_b, bus.rd_result};
    endfunction

    // Independent reference using the simulator's own 64-bit signed arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] res, output logic err);
        longint sa, sb, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = 0;
        err = 1'b0;
        case (op)
            OP_PASSA: r = sa;
            OP_PASSB: r = sb;
            OP_ADD:   r = sa + sb;
            OP_SUB:   r = sa - sb;
            OP_MULT:  r = sa * sb;
            OP_DIV:   if (sb == 0) err = 1'b1; else r = sa / sb;
            OP_MOD:   if (sb == 0) err = 1'b1; else r = sa % sb;
            default:  r = 0;
        endcase
        res = r;
    endfunction

    task automatic add_vec(input logic [2:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [ADDR_W-1:0] ptr, input logic [RES_W-1:0] res, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.ptr = ptr; v.res = res; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    endtask

    // Called right after a negedge; returns right after the negedge at which wr_ready=1.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus.wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.wr_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: wr_ready stuck at 0 for %0d cycles, required 1", name, n);
        end
    endtask

    task automatic drive_wr(input logic [2:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [ADDR_W-1:0] ptr);
        bus.wr_valid      = 1'b1;
        bus.opcode        = op;
        bus.operand_a     = a;
        bus.operand_b     = b;
        bus.write_pointer = ptr;
    endtask

    // Pop the scoreboard head and compare it with the read port (one cycle after rd_req).
    task automatic collect_read(input string name);
        entry_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, rd_valid=%0b", name, bus.rd_valid);
        end else begin
            e = exp_q.pop_front();
            check(name, 256'({bus.rd_valid, rd_entry()}), 256'({1'b1, e}));
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] ptr, input string name);
        bus.rd_req       = 1'b1;
        bus.read_pointer = ptr;
        exp_q.push_back(shadow[ptr]);
        @(negedge clk);
        bus.rd_req = 1'b0;
        collect_read(name);
    endtask

    // Issue one instruction, check commit latency, wr_ready low time and the wr_done pulse.
    task automatic do_write(input logic [2:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [ADDR_W-1:0] ptr, input logic [RES_W-1:0] res, input logic err,
                            input string name);
        int lat, low, exp_lat;
        wait_ready({name, "_ready"});
        drive_wr(op, a, b, ptr);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        lat = 1;
        low = 0;
        while (!bus.wr_done && lat < 100) begin
            if (!bus.wr_ready) low++;
            @(negedge clk);
            lat++;
        end
        exp_lat = ((op == OP_DIV || op == OP_MOD) && b != '0) ? DATA_W + 3 : 2;
        check({name, "_latency"}, 256'(lat), 256'(exp_lat));
        check({name, "_ready_low"}, 256'(low), 256'(exp_lat - 1));
        shadow[ptr] = {1'b1, err, op, a, b, res};
        @(negedge clk);
        check({name, "_done_pulse"}, 256'(bus.wr_done), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RES_W-1:0]  r;
        logic              e;
        logic [DATA_W-1:0] ra, rb;
        logic [2:0]        rop;
        int                n;

        bus.wr_valid = 1'b0; bus.opcode = '0; bus.operand_a = '0; bus.operand_b = '0;
        bus.write_pointer = '0; bus.rd_req = 1'b0; bus.read_pointer = '0;
        clear_shadow();

        // Table: inputs and hand-computed expected results.
        add_vec(OP_ADD,   -32'sd7,       32'sd5,        5'd0,  -64'sd2,   1'b0);
        add_vec(OP_SUB,   32'sd3,        32'sd10,       5'd1,  -64'sd7,   1'b0);
        add_vec(OP_MULT,  -32'sd15,      32'sd15,       5'd2,  -64'sd225, 1'b0);
        add_vec(OP_DIV,   -32'sd15,      32'sd4,        5'd3,  -64'sd3,   1'b0);
        add_vec(OP_MOD,   -32'sd15,      32'sd4,        5'd4,  -64'sd3,   1'b0);
        add_vec(OP_DIV,   32'sd9,        32'sd0,        5'd6,  64'sd0,    1'b1);
        add_vec(OP_PASSA, 32'sd123,      -32'sd1,       5'd7,  64'sd123,  1'b0);
        add_vec(OP_PASSB, 32'sd1,        -32'sd456,     5'd8,  -64'sd456, 1'b0);
        add_vec(OP_ZERO,  32'sd5,        32'sd6,        5'd9,  64'sd0,    1'b0);
        add_vec(OP_ADD,   32'h7FFF_FFFF, 32'sd1,        5'd10, 64'h0000_0000_8000_0000, 1'b0);
        add_vec(OP_SUB,   32'h8000_0000, 32'sd1,        5'd11, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0);
        add_vec(OP_MULT,  32'h8000_0000, 32'h8000_0000, 5'd12, 64'h4000_0000_0000_0000, 1'b0);
        add_vec(OP_DIV,   32'sd100,      -32'sd7,       5'd13, -64'sd14,  1'b0);
        add_vec(OP_MOD,   32'sd100,      -32'sd7,       5'd14, 64'sd2,    1'b0);
        add_vec(OP_DIV,   32'h8000_0000, -32'sd1,       5'd15, 64'h0000_0000_8000_0000, 1'b0);
        add_vec(OP_MOD,   32'sd7,        32'sd0,        5'd16, 64'sd0,    1'b1);
        add_vec(OP_MOD,   -32'sd7,       -32'sd7,       5'd17, 64'sd0,    1'b0);
        add_vec(OP_DIV,   32'sd7,        32'sd9,        5'd18, 64'sd0,    1'b0);

        // Reset held for two edges, then every entry reads back empty.
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("reset_flags", 256'({bus.wr_ready, bus.wr_done, bus.rd_valid}), 256'(3'b100));
        check("reset_rd_fields", 256'(rd_entry()), 256'(0));
        for (int p = 0; p < DEPTH; p++) do_read(ADDR_W'(p), $sformatf("reset_read[%0d]", p));

        // Table-driven writes with read-back.
        foreach (tbl[i]) begin
            do_write(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ptr, tbl[i].res, tbl[i].err,
                     $sformatf("vec%0d", i));
            do_read(tbl[i].ptr, $sformatf("vec%0d_read", i));
        end
        // rd_valid is a single-cycle pulse and the rd_* fields hold afterwards.
        @(negedge clk);
        check("rd_hold", 256'({bus.rd_valid, rd_entry()}), 256'({1'b0, shadow[18]}));

        // Random operands checked against the reference model.
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 20)) - 32'd10);
            model(rop, ra, rb, r, e);
            do_write(rop, ra, rb, ADDR_W'(22 + i), r, e, $sformatf("rand%0d", i));
            do_read(ADDR_W'(22 + i), $sformatf("rand%0d_read", i));
        end

        // Reset ten cycles into a divide: the instruction is dropped.
        wait_ready("mid_div_ready");
        drive_wr(OP_DIV, 32'sd100, 32'sd7, 5'd5);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_shadow();
        check("mid_div_reset_rd", 256'({bus.rd_valid, rd_entry()}), 256'(0));
        @(negedge clk);
        check("mid_div_after_release", 256'({bus.wr_ready, bus.wr_done}), 256'(2'b10));
        do_read(5'd5, "mid_div_ptr5");
        repeat (DATA_W + 4) @(negedge clk);
        do_read(5'd5, "mid_div_ptr5_late");
        do_read(5'd3, "mid_div_ptr3_cleared");

        // Offer held high across a divide: next accept only once back in IDLE.
        wait_ready("bp_ready");
        drive_wr(OP_DIV, -32'sd1000, 32'sd33, 5'd20);
        @(negedge clk);
        drive_wr(OP_ADD, 32'sd40, 32'sd2, 5'd21);
        n = 1;
        while (!bus.wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_accept_wait", 256'(n), 256'(DATA_W + 3));
        @(negedge clk);
        bus.wr_valid = 1'b0;
        check("bp_second_accepted", 256'(bus.wr_ready), 256'(0));
        n = 0;
        while (!bus.wr_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_second_done", 256'(bus.wr_done), 256'(1));
        shadow[20] = {1'b1, 1'b0, OP_DIV, -32'sd1000, 32'sd33, -64'sd30};
        shadow[21] = {1'b1, 1'b0, OP_ADD, 32'sd40, 32'sd2, 64'sd42};
        do_read(5'd20, "bp_read20");
        do_read(5'd21, "bp_read21");

        // Highest entry then entry 0.
        do_write(OP_ADD, 32'sd1, 32'sd1, 5'd31, 64'sd2, 1'b0, "wrap_hi");
        do_write(OP_SUB, 32'sd50, 32'sd8, 5'd0, 64'sd42, 1'b0, "wrap_lo");
        do_read(5'd31, "wrap_read31");
        do_read(5'd0, "wrap_read0");

        // Read of entry 0 on its own commit edge returns the old contents.
        wait_ready("coll_ready");
        drive_wr(OP_MULT, 32'sd6, -32'sd7, 5'd0);
        @(negedge clk);
        bus.wr_valid     = 1'b0;
        bus.rd_req       = 1'b1;
        bus.read_pointer = 5'd0;
        exp_q.push_back(shadow[0]);
        @(negedge clk);
        bus.rd_req = 1'b0;
        collect_read("collision_old");
        check("collision_wr_done", 256'(bus.wr_done), 256'(1));
        shadow[0] = {1'b1, 1'b0, OP_MULT, 32'sd6, -32'sd7, -64'sd42};
        @(negedge clk);
        do_read(5'd0, "collision_new");

        check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
